// File: rtl/tr_pkg.sv
// tr_pkg: shared band/state types for the tracking step regulator.
package tr_pkg;
    localparam int BAND_W = 2;
    typedef enum logic [BAND_W-1:0] {HOLD = 2'd0, SLOW = 2'd1, FAST = 2'd2} band_t;
    typedef enum logic [1:0] {IDLE, DIR_WAIT, PULSE_HI, PULSE_LO} state_t;
endpackage

// File: rtl/tr_step_gen.sv
// tr_step_gen: step/dir pulse FSM; period chosen by band at each rise, reversal inserts a setup wait.
module tr_step_gen
    import tr_pkg::*;
#(
    parameter int DIV_SLOW  = 1000,
    parameter int DIV_FAST  = 100,
    parameter int PULSE_W   = 1,
    parameter int DIR_SETUP = 50
) (
    input  logic  clk,
    input  logic  rst_n,
    input  logic  enable,
    input  band_t band,
    input  logic  req_dir,
    output logic  drv_step,
    output logic  drv_dir
);
    localparam int CW = $clog2((DIV_SLOW > DIR_SETUP ? DIV_SLOW : DIR_SETUP) + 1);

    state_t        state, state_n;
    logic [CW-1:0] pcnt, pcnt_n, last;
    logic          fast, fast_n, dir_n, go;

    assign go       = band != HOLD;
    assign last     = fast ? CW'(DIV_FAST - 1) : CW'(DIV_SLOW - 1);
    assign drv_step = enable && state == PULSE_HI;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= IDLE;
            pcnt    <= '0;
            fast    <= 1'b0;
            drv_dir <= 1'b0;
        end else begin
            state   <= state_n;
            pcnt    <= pcnt_n;
            fast    <= fast_n;
            drv_dir <= dir_n;
        end

    // pcnt counts cycles since the rise (or since the dir change in DIR_WAIT)
    always_comb begin
        state_n = state;
        pcnt_n  = pcnt + 1'b1;
        fast_n  = fast;
        dir_n   = drv_dir;
        if (!enable) begin
            state_n = IDLE;
            pcnt_n  = '0;
        end else case (state)
            IDLE: begin
                pcnt_n = '0;
                if (go && req_dir == drv_dir) begin
                    state_n = PULSE_HI;
                    fast_n  = band == FAST;
                end else if (go) begin
                    state_n = DIR_WAIT;
                    dir_n   = req_dir;
                end
            end
            DIR_WAIT:
                if (pcnt == CW'(DIR_SETUP - 1)) begin
                    pcnt_n  = '0;
                    state_n = go ? PULSE_HI : IDLE;
                    fast_n  = band == FAST;
                end
            PULSE_HI:
                if (pcnt == CW'(PULSE_W - 1)) state_n = PULSE_LO;
            PULSE_LO:
                if (pcnt == last) begin
                    pcnt_n = '0;
                    if (!go) state_n = IDLE;
                    else if (req_dir != drv_dir) begin
                        state_n = DIR_WAIT;
                        dir_n   = req_dir;
                    end else begin
                        state_n = PULSE_HI;
                        fast_n  = band == FAST;
                    end
                end
        endcase
    end
endmodule

// File: rtl/tr_step_regulator.sv
// tr_step_regulator: error banding, stale-data watchdog and stepper drive toward x == x0.
// Define TR_STEP_COUNT_EN to add the signed step position counter on port pos.
module tr_step_regulator
    import tr_pkg::*;
#(
    parameter int AW        = 12,
    parameter int DIV_SLOW  = 1000,
    parameter int DIV_FAST  = 100,
    parameter int PULSE_W   = 1,
    parameter int DIR_SETUP = 50,
    parameter int WDOG_CYC  = 5000,
    parameter int PW        = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              enable,
    input  logic              data_valid,
    input  logic [AW-1:0]     x,
    input  logic [AW-1:0]     x0,
    input  logic [AW-1:0]     dx1,
    input  logic [AW-1:0]     dx2,
    output logic              drv_en,
    output logic              drv_step,
    output logic              drv_dir,
    output logic [BAND_W-1:0] band,
    output logic              stale
`ifdef TR_STEP_COUNT_EN
    ,
    output logic [PW-1:0]     pos
`endif
);
    localparam int WW = $clog2(WDOG_CYC + 1);

    if (PW < 1 || DIV_FAST <= PULSE_W || DIV_FAST > DIV_SLOW) begin : g_bad_param
        $error("tr_step_regulator: illegal PW/DIV_FAST/PULSE_W/DIV_SLOW combination");
    end

    logic [AW-1:0] mag;
    logic [WW-1:0] wcnt;
    band_t         band_q, band_n;
    logic          req_dir;

    assign mag    = x >= x0 ? x - x0 : x0 - x;
    assign band_n = mag <= dx1 ? HOLD : mag > dx2 ? FAST : SLOW;
    assign band   = band_q;

    // a data_valid in the expiry cycle takes priority, so stale never rises then
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            drv_en  <= 1'b0;
            stale   <= 1'b0;
            wcnt    <= '0;
            band_q  <= HOLD;
            req_dir <= 1'b0;
        end else begin
            drv_en <= enable;
            if (data_valid) begin
                wcnt    <= '0;
                stale   <= 1'b0;
                band_q  <= band_n;
                req_dir <= x > x0;
            end else if (!stale) begin
                wcnt <= wcnt + 1'b1;
                if (wcnt == WW'(WDOG_CYC - 1)) begin
                    stale  <= 1'b1;
                    band_q <= HOLD;
                end
            end
        end

    tr_step_gen #(
        .DIV_SLOW (DIV_SLOW),
        .DIV_FAST (DIV_FAST),
        .PULSE_W  (PULSE_W),
        .DIR_SETUP(DIR_SETUP)
    ) u_gen (
        .clk     (clk),
        .rst_n   (rst_n),
        .enable  (enable),
        .band    (band_q),
        .req_dir (req_dir),
        .drv_step(drv_step),
        .drv_dir (drv_dir)
    );

`ifdef TR_STEP_COUNT_EN
    logic step_q;

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            step_q <= 1'b0;
            pos    <= '0;
        end else begin
            step_q <= drv_step;
            if (drv_step && !step_q) pos <= drv_dir ? pos - 1'b1 : pos + 1'b1;
        end
`endif
endmodule
